pipe_stage_skid_reg: RTL and testbench
======================================

Name: pipe_stage_skid_reg

Overview:
Generic, parametrised pipeline-stage register that replaces per-stage hand-written latches such as ID/EX and EX/MEM with a single reusable block. Payload is an opaque DATA_W-bit bundle, packed by the instantiating stage. Moves the old single enable to a full valid/ready handshake with an optional 2-entry skid buffer, so that ready is registered and cuts the combinational stall path. Adds pipeline flush for branch mispredict/annul/trap, occupancy output and a saturating stall-cycle performance counter.

Parameters:
DATA_W, 256, payload width in bits (>=1)
SKID, 1, 1 = 2-entry skid buffer with registered in_ready; 0 = single entry with combinational in_ready
CNT_W, 16, width of stall counter (>=2)

Ports:
clk  input  1  clock, all state updates on posedge
reset  input  1  reset, synchronous, active-high
in_valid  input  1  upstream stage presents a beat
in_ready  output  1  stage can accept a beat this cycle
in_data  input  DATA_W  upstream payload
flush  input  1  kill all held beats (mispredict/annul/trap)
out_valid  output  1  stage holds a beat for downstream
out_ready  input  1  downstream accepts
out_data  output  DATA_W  payload of oldest held beat
occupancy  output  2  number of held beats (0..2)
stall_cnt  output  CNT_W  cycles with out_valid=1 and out_ready=0, saturating

Behaviour:
- Internal state: main entry (main_v, main_d) and skid entry (skid_v, skid_d); the skid entry exists only when SKID=1.
- out_valid=main_v; out_data=main_d; occupancy=main_v+skid_v.
- Fire definitions: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- Reset: main_v=0, skid_v=0, main_d=0, skid_d=0, stall_cnt=0. Reset has priority over flush and all handshakes. Reset mid-stream discards held beats.
- Reset outputs: out_valid=0; out_data=0; occupancy=0; stall_cnt=0; in_ready=1 from the first cycle after reset.
- SKID=1: in_ready = !skid_v, a pure flop output. States are EMPTY (main_v=0), FULL (main_v=1, skid_v=0) and SKID (both valid).
- EMPTY, in_fire -> FULL, main_d<=in_data.
- EMPTY, no in_fire -> stay EMPTY.
- FULL, out_fire & in_fire -> FULL, main_d<=in_data.
- FULL, out_fire & !in_fire -> EMPTY.
- FULL, !out_ready & in_fire -> SKID, skid_d<=in_data.
- FULL, !out_ready & !in_fire -> hold.
- SKID: in_ready=0. out_fire -> FULL, main_d<=skid_d. Otherwise hold.
- SKID=0: in_ready = !main_v | out_ready (combinational). Only EMPTY and FULL are reachable, with the same transitions as above.
- Latency: 1 cycle from in_fire to out_valid. Throughput 1 beat/cycle when out_ready=1.
- Beats leave strictly in acceptance order. No beat is duplicated or dropped except by flush.
- Held data is stable while out_valid=1 & out_ready=0.
- flush=1: next cycle main_v=0 and skid_v=0. A beat with in_fire in the same cycle as flush is discarded.
- flush does not clear the data registers. flush does not affect stall_cnt.
- in_ready during the flush cycle follows normal rules. After flush, the stage is EMPTY with in_ready=1.
- stall_cnt: increments by 1 on any cycle with out_valid & !out_ready, including the flush cycle. It saturates at 2^CNT_W-1 and holds there. Only reset clears it.

Test Plan:
- Reset: drive reset=1 for 2 cycles with in_valid=1, in_data=0xAA -> out_valid=0, out_data=0, occupancy=0, stall_cnt=0; in_ready=1 the cycle after reset deasserts.
- Streaming: out_ready=1, in_valid=1, in_data=1,2,3,4 on consecutive cycles -> out_data=1,2,3,4 one cycle later, out_valid continuous, occupancy=1, in_ready stays 1.
- Backpressure (SKID=1): out_ready=0, push 0x10 then 0x11 -> occupancy=2, in_ready=0, 0x12 not accepted, stall_cnt=1 after the first stalled cycle. Then raise out_ready -> outputs 0x10, 0x11, 0x12 in order.
- Flush: SKID state holding 0x20/0x21, assert flush with in_valid=1, in_data=0x22 -> next cycle out_valid=0, occupancy=0, in_ready=1; 0x22 never appears at the output.
- Counter saturation: CNT_W=4, hold out_valid=1, out_ready=0 for 20 cycles -> stall_cnt reaches 15 and stays 15. Then flush -> stall_cnt stays 15.
- SKID=0 mode: stage FULL with out_ready=0 -> in_ready=0. Raise out_ready with in_valid=1 -> in_ready=1 in the same cycle, and the beat is replaced without a bubble.

Source files
------------

// File: rtl/pipe_stage_skid_reg.sv
// ---------------------------------------------------------------------------
// pipe_stage_skid_reg
//   Reusable pipeline-stage register with a valid/ready handshake. It replaces
//   hand-written inter-stage latches (ID/EX, EX/MEM, ...). The payload is an
//   opaque DATA_W-bit bundle that the instantiating stage packs.
//
//   SKID=1 : 2-entry (main + skid) buffer. in_ready is taken straight from a
//            flop, so the upstream stall path carries no downstream logic.
//   SKID=0 : single entry. in_ready is combinational (!main_v | out_ready).
//
//   flush empties the stage (held beats are killed, as is any beat accepted
//   in the same cycle). The data registers are left untouched by flush.
//   stall_cnt counts cycles with out_valid & !out_ready. It saturates and is
//   cleared only by reset.
//
// Ports
//   clk        clock, all state updates on posedge
//   reset      synchronous, active-high; highest priority
//   in_valid   upstream presents a beat
//   in_ready   stage can accept a beat this cycle
//   in_data    upstream payload [DATA_W]
//   flush      kill all held beats
//   out_valid  stage holds a beat for downstream
//   out_ready  downstream accepts
//   out_data   payload of the oldest held beat [DATA_W]
//   occupancy  number of held beats, 0..2
//   stall_cnt  saturating stall-cycle counter [CNT_W]
// ---------------------------------------------------------------------------
module pipe_stage_skid_reg #(
   parameter int DATA_W = 256,
   parameter int SKID   = 1,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [1:0]        occupancy,
   output logic [CNT_W-1:0]  stall_cnt
);

   logic              main_v;
   logic [DATA_W-1:0] main_d;
   logic              skid_v;
   logic              in_fire;
   logic              out_fire;

   // Saturating increment: the counter holds at all-ones.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   assign in_fire   = in_valid & in_ready;
   assign out_fire  = main_v & out_ready;
   assign out_valid = main_v;
   assign out_data  = main_d;
   assign occupancy = {1'b0, main_v} + {1'b0, skid_v};

   generate
      if (SKID != 0) begin : g_skid
         logic [DATA_W-1:0] skid_d;

         // The skid entry absorbs the one beat accepted while downstream stalls,
         // which lets in_ready be a registered signal.
         assign in_ready = ~skid_v;

         always_ff @(posedge clk) begin
            if (reset) begin
               main_v <= 1'b0;
               skid_v <= 1'b0;
               main_d <= '0;
               skid_d <= '0;
            end else if (flush) begin
               main_v <= 1'b0;
               skid_v <= 1'b0;
            end else if (!main_v) begin
               if (in_fire) begin
                  main_v <= 1'b1;
                  main_d <= in_data;
               end
            end else if (!skid_v) begin
               if (out_fire) begin
                  if (in_fire) main_d <= in_data;
                  else         main_v <= 1'b0;
               end else if (in_fire) begin
                  skid_v <= 1'b1;
                  skid_d <= in_data;
               end
            end else if (out_fire) begin
               // in_ready is low here, so no new beat can arrive this cycle.
               main_d <= skid_d;
               skid_v <= 1'b0;
            end
         end
      end else begin : g_noskid
         assign skid_v   = 1'b0;
         // A full stage may still accept when the held beat leaves this cycle.
         assign in_ready = ~main_v | out_ready;

         always_ff @(posedge clk) begin
            if (reset) begin
               main_v <= 1'b0;
               main_d <= '0;
            end else if (flush) begin
               main_v <= 1'b0;
            end else if (!main_v) begin
               if (in_fire) begin
                  main_v <= 1'b1;
                  main_d <= in_data;
               end
            end else if (out_fire) begin
               if (in_fire) main_d <= in_data;
               else         main_v <= 1'b0;
            end
         end
      end
   endgenerate

   // Stall counter; flush does not affect it.
   always_ff @(posedge clk) begin
      if (reset) begin
         stall_cnt <= '0;
      end else if (main_v && !out_ready) begin
         stall_cnt <= sat_inc(stall_cnt);
      end
   end

endmodule

// File: tb/tb_pipe_stage_skid_reg.sv
// ---------------------------------------------------------------------------
// tb_pipe_stage_skid_reg
//   Two instances share one stimulus stream: u0 with SKID=1 and u1 with
//   SKID=0, both with DATA_W=16 and CNT_W=4. A FIFO-capacity reference model
//   per instance is compared every cycle. A hand-derived vector table covers
//   reset, streaming, backpressure and flush on u0. Short sequences then cover
//   SKID=0 pass-through and counter saturation, followed by random traffic.
// ---------------------------------------------------------------------------
module tb_pipe_stage_skid_reg;

   localparam int DW = 16;
   localparam int CW = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          reset, in_valid, flush, out_ready;
   logic [DW-1:0] in_data;

   logic [1:0]         ir, ov;
   logic [1:0][DW-1:0] od;
   logic [1:0][1:0]    occ;
   logic [1:0][CW-1:0] sc;

   pipe_stage_skid_reg #(.DATA_W(DW), .SKID(1), .CNT_W(CW)) u0 (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir[0]),
      .in_data(in_data), .flush(flush), .out_valid(ov[0]), .out_ready(out_ready),
      .out_data(od[0]), .occupancy(occ[0]), .stall_cnt(sc[0]));

   pipe_stage_skid_reg #(.DATA_W(DW), .SKID(0), .CNT_W(CW)) u1 (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir[1]),
      .in_data(in_data), .flush(flush), .out_valid(ov[1]), .out_ready(out_ready),
      .out_data(od[1]), .occupancy(occ[1]), .stall_cnt(sc[1]));

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // ---------------- reference model: bounded FIFO per instance ------------
   bit            model_on = 1'b0;
   int            n    [2];
   logic [DW-1:0] fifo [2][2];
   int            mcnt [2];
   logic [DW-1:0] last [2];

   function automatic bit exp_ready(input int i);
      if (i == 0) return n[i] < 2;
      return (n[i] == 0) || out_ready;
   endfunction

   task automatic check_models();
      if (model_on) begin
         for (int i = 0; i < 2; i++) begin
            chk($sformatf("u%0d.out_valid", i), 32'(ov[i]), 32'(n[i] > 0));
            chk($sformatf("u%0d.out_data", i), 32'(od[i]),
                32'((n[i] > 0) ? fifo[i][0] : last[i]));
            chk($sformatf("u%0d.occupancy", i), 32'(occ[i]), 32'(n[i]));
            chk($sformatf("u%0d.in_ready", i), 32'(ir[i]), 32'(exp_ready(i)));
            chk($sformatf("u%0d.stall_cnt", i), 32'(sc[i]), 32'(mcnt[i]));
         end
      end
   endtask

   task automatic model_step();
      for (int i = 0; i < 2; i++) begin
         if (reset) begin
            n[i] = 0; mcnt[i] = 0; last[i] = '0;
         end else if (model_on) begin
            bit rdy, inf, outf;
            rdy = exp_ready(i);
            if (n[i] > 0 && !out_ready && mcnt[i] < (1 << CW) - 1) mcnt[i]++;
            if (flush) begin
               n[i] = 0;
            end else begin
               inf  = in_valid && rdy;
               outf = (n[i] > 0) && out_ready;
               if (outf) begin
                  fifo[i][0] = fifo[i][1];
                  n[i]--;
               end
               if (inf) begin
                  fifo[i][n[i]] = in_data;
                  n[i]++;
               end
            end
            if (n[i] > 0) last[i] = fifo[i][0];
         end
      end
      if (reset) model_on = 1'b1;
   endtask

   // Drive inputs, then check at the following negedge.
   task automatic apply(input logic r, input logic v, input logic [DW-1:0] d,
                        input logic f, input logic o);
      reset = r; in_valid = v; in_data = d; flush = f; out_ready = o;
      @(negedge clk);
      check_models();
   endtask

   task automatic adv();
      @(posedge clk);
      model_step();
      #1;
   endtask

   // ---------------- hand-derived vector table for u0 (SKID=1) -------------
   typedef struct {
      logic          rst, iv;
      logic [DW-1:0] d;
      logic          fl, ordy, chk_en, ov;
      logic [DW-1:0] od;
      logic [1:0]    occ;
      logic          ir;
      logic [CW-1:0] cnt;
   } vec_t;

   vec_t tbl [20];

   function automatic vec_t mk(input logic rst, iv, input logic [DW-1:0] d,
                               input logic fl, ordy, ce, eov, input logic [DW-1:0] eod,
                               input logic [1:0] eocc, input logic eir,
                               input logic [CW-1:0] ecnt);
      vec_t t;
      t.rst = rst; t.iv = iv; t.d = d; t.fl = fl; t.ordy = ordy; t.chk_en = ce;
      t.ov = eov; t.od = eod; t.occ = eocc; t.ir = eir; t.cnt = ecnt;
      return t;
   endfunction

   initial begin
      //            rst iv  d      fl or  ce  ov  od     occ ir cnt
      tbl[0]  = mk(1, 1, 16'hAA, 0, 1, 0, 0, 16'h00, 0, 1, 0);
      tbl[1]  = mk(1, 1, 16'hAA, 0, 1, 1, 0, 16'h00, 0, 1, 0);
      tbl[2]  = mk(0, 1, 16'h01, 0, 1, 1, 0, 16'h00, 0, 1, 0);
      tbl[3]  = mk(0, 1, 16'h02, 0, 1, 1, 1, 16'h01, 1, 1, 0);
      tbl[4]  = mk(0, 1, 16'h03, 0, 1, 1, 1, 16'h02, 1, 1, 0);
      tbl[5]  = mk(0, 1, 16'h04, 0, 1, 1, 1, 16'h03, 1, 1, 0);
      tbl[6]  = mk(0, 0, 16'h00, 0, 1, 1, 1, 16'h04, 1, 1, 0);
      tbl[7]  = mk(0, 1, 16'h10, 0, 0, 1, 0, 16'h04, 0, 1, 0);
      tbl[8]  = mk(0, 1, 16'h11, 0, 0, 1, 1, 16'h10, 1, 1, 0);
      tbl[9]  = mk(0, 1, 16'h12, 0, 0, 1, 1, 16'h10, 2, 0, 1);
      tbl[10] = mk(0, 1, 16'h12, 0, 1, 1, 1, 16'h10, 2, 0, 2);
      tbl[11] = mk(0, 1, 16'h12, 0, 1, 1, 1, 16'h11, 1, 1, 2);
      tbl[12] = mk(0, 0, 16'h00, 0, 1, 1, 1, 16'h12, 1, 1, 2);
      tbl[13] = mk(0, 1, 16'h20, 0, 0, 1, 0, 16'h12, 0, 1, 2);
      tbl[14] = mk(0, 1, 16'h21, 0, 0, 1, 1, 16'h20, 1, 1, 2);
      tbl[15] = mk(0, 1, 16'h22, 1, 0, 1, 1, 16'h20, 2, 0, 3);
      tbl[16] = mk(0, 0, 16'h00, 0, 1, 1, 0, 16'h20, 0, 1, 4);
      tbl[17] = mk(0, 1, 16'h30, 0, 0, 1, 0, 16'h20, 0, 1, 4);
      tbl[18] = mk(0, 1, 16'h31, 1, 0, 1, 1, 16'h30, 1, 1, 4);
      tbl[19] = mk(0, 0, 16'h00, 0, 1, 1, 0, 16'h30, 0, 1, 5);

      reset = 1'b1; in_valid = 1'b0; in_data = '0; flush = 1'b0; out_ready = 1'b0;

      for (int k = 0; k < 20; k++) begin
         apply(tbl[k].rst, tbl[k].iv, tbl[k].d, tbl[k].fl, tbl[k].ordy);
         if (tbl[k].chk_en) begin
            chk($sformatf("tbl%0d.out_valid", k), 32'(ov[0]),  32'(tbl[k].ov));
            chk($sformatf("tbl%0d.out_data", k),  32'(od[0]),  32'(tbl[k].od));
            chk($sformatf("tbl%0d.occupancy", k), 32'(occ[0]), 32'(tbl[k].occ));
            chk($sformatf("tbl%0d.in_ready", k),  32'(ir[0]),  32'(tbl[k].ir));
            chk($sformatf("tbl%0d.stall_cnt", k), 32'(sc[0]),  32'(tbl[k].cnt));
         end
         adv();
      end

      // SKID=0: full stage stalls combinationally, then passes through with no bubble.
      apply(0, 0, 16'h0, 0, 1); adv();
      apply(0, 1, 16'h40, 0, 0); adv();
      apply(0, 0, 16'h0, 0, 0);
      chk("noskid.full_in_ready", 32'(ir[1]), 32'd0);
      chk("noskid.full_valid", 32'(ov[1]), 32'd1);
      adv();
      apply(0, 1, 16'h41, 0, 1);
      chk("noskid.pass_in_ready", 32'(ir[1]), 32'd1);
      chk("noskid.pass_data_old", 32'(od[1]), 32'h40);
      adv();
      apply(0, 0, 16'h0, 0, 1);
      chk("noskid.no_bubble_valid", 32'(ov[1]), 32'd1);
      chk("noskid.no_bubble_data", 32'(od[1]), 32'h41);
      adv();

      // Counter saturation, and flush leaves the counter alone.
      apply(1, 0, 16'h0, 0, 0); adv();
      apply(0, 1, 16'h50, 0, 0); adv();
      for (int k = 0; k < 20; k++) begin
         apply(0, 0, 16'h0, 0, 0); adv();
      end
      apply(0, 0, 16'h0, 0, 0);
      chk("sat.u0_cnt", 32'(sc[0]), 32'd15);
      chk("sat.u1_cnt", 32'(sc[1]), 32'd15);
      adv();
      apply(0, 1, 16'h51, 1, 0); adv();
      apply(0, 0, 16'h0, 0, 0);
      chk("sat.after_flush_cnt", 32'(sc[0]), 32'd15);
      chk("sat.after_flush_valid", 32'(ov[0]), 32'd0);
      chk("sat.after_flush_ready", 32'(ir[0]), 32'd1);
      adv();

      // Random traffic against the model.
      for (int k = 0; k < 500; k++) begin
         apply(($urandom % 64) == 0, ($urandom % 4) != 0, DW'($urandom),
               ($urandom % 16) == 0, ($urandom % 3) != 0);
         adv();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
